// File: rtl/register_file_1r_64b_multi_port_write_32b_pkg.sv
// Shared helpers for the 64b-read / 32b-write latch register file.
// The package holds no typedefs; the file derives its word count locally from this helper.
package register_file_1r_64b_multi_port_write_32b_pkg;

    function automatic int unsigned wordCount(int unsigned addrWidth);
        return 32'd1 << addrWidth;
    endfunction

endpackage

// File: rtl/tc_clk_gating.sv
// Behavioural model of the technology clock-gating cell.
// The enable is captured while the clock is low, so the gated clock never glitches.
module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_q;

    always_latch begin
        if (!clk_i) begin
            en_q <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_q;

endmodule

// File: rtl/register_file_1r_64b_multi_port_write_32b.sv
// Latch-based register file: one registered 64b read port, N_WRITE 32b write ports.
// Each 32b word is a latch opened by its own gated clock during the high phase after a write edge.
module register_file_1r_64b_multi_port_write_32b
    import register_file_1r_64b_multi_port_write_32b_pkg::*;
#(
    parameter int RADDR_WIDTH = 5,
    parameter int RDATA_WIDTH = 64,
    parameter int WDATA_WIDTH = 32,
    parameter int WADDR_WIDTH = RADDR_WIDTH + 1,
    parameter int N_WRITE     = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    ReadEnable,
    input  logic [RADDR_WIDTH-1:0]                  ReadAddr,
    output logic [RDATA_WIDTH-1:0]                  ReadData,
    input  logic [N_WRITE-1:0]                      WriteEnable,
    input  logic [N_WRITE-1:0][WADDR_WIDTH-1:0]     WriteAddr,
    input  logic [N_WRITE-1:0][WDATA_WIDTH-1:0]     WriteData,
    output logic [N_WRITE-1:0]                      WriteDropped
);

    localparam int unsigned NUM_WORDS = wordCount(WADDR_WIDTH);

    logic [RADDR_WIDTH-1:0]                  raddr_q;
    logic [N_WRITE-1:0]                      we_q;
    logic [N_WRITE-1:0][WADDR_WIDTH-1:0]     waddr_q;
    logic [N_WRITE-1:0][WDATA_WIDTH-1:0]     wdata_q;
    logic [N_WRITE-1:0]                      dropped_d;
    logic [N_WRITE-1:0]                      dropped_q;
    logic [NUM_WORDS-1:0]                    wordEn;
    logic [NUM_WORDS-1:0]                    wordClk;
    logic [WDATA_WIDTH-1:0]                  wordData [NUM_WORDS];
    logic [WDATA_WIDTH-1:0]                  memWord  [NUM_WORDS];
    logic                                    globalEn;
    logic                                    globalClk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q   <= '0;
            we_q      <= '0;
            dropped_q <= '0;
        end else begin
            if (ReadEnable) begin
                raddr_q <= ReadAddr;
            end
            we_q      <= WriteEnable;
            dropped_q <= dropped_d;
        end
    end

    // Data and address only matter while the matching staged enable is set.
    always_ff @(posedge clk) begin
        waddr_q <= WriteAddr;
        wdata_q <= WriteData;
    end

    always_comb begin
        wordEn    = '0;
        dropped_d = '0;
        for (int p = 0; p < N_WRITE; p++) begin
            if (WriteEnable[p]) begin
                wordEn[WriteAddr[p]] = 1'b1;
            end
            for (int q = 0; q < N_WRITE; q++) begin
                if (q < p && WriteEnable[q] && WriteEnable[p] && WriteAddr[q] == WriteAddr[p]) begin
                    dropped_d[p] = 1'b1;
                end
            end
        end
    end

    // Scanning from the highest port down lets the lowest-index requester overwrite last and win.
    always_comb begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            wordData[w] = '0;
            for (int p = N_WRITE - 1; p >= 0; p--) begin
                if (we_q[p] && waddr_q[p] == WADDR_WIDTH'(w)) begin
                    wordData[w] = wdata_q[p];
                end
            end
        end
    end

    assign globalEn = (|WriteEnable) & rst_n;

    tc_clk_gating i_globalGate (
        .clk_i    (clk),
        .en_i     (globalEn),
        .test_en_i(1'b0),
        .clk_o    (globalClk)
    );

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        logic [WDATA_WIDTH-1:0] word_q;

        tc_clk_gating i_wordGate (
            .clk_i    (globalClk),
            .en_i     (wordEn[w] & rst_n),
            .test_en_i(1'b0),
            .clk_o    (wordClk[w])
        );

        always_latch begin
            if (wordClk[w]) begin
                word_q <= wordData[w];
            end
        end

        assign memWord[w] = word_q;
    end

    assign ReadData     = {memWord[{raddr_q, 1'b1}], memWord[{raddr_q, 1'b0}]};
    assign WriteDropped = dropped_q;

endmodule

// File: doc/register_file_1r_64b_multi_port_write_32b.md
REGISTER_FILE_1R_64B_MULTI_PORT_WRITE_32B -- requirements
Module: register_file_1r_64b_multi_port_write_32b

Interface
REQ-001 SHALL have parameter RADDR_WIDTH, default 5, meaning the 64b read-word address width.
REQ-002 SHALL have parameter RDATA_WIDTH, default 64, meaning the read-word width.
REQ-003 SHALL have parameter WDATA_WIDTH, default 32, meaning the write-word width; RDATA_WIDTH = 2*WDATA_WIDTH.
REQ-004 SHALL have parameter WADDR_WIDTH, default RADDR_WIDTH+1, meaning the 32b write-word address width.
REQ-005 SHALL have parameter N_WRITE, default 4, meaning the number of write ports (at least 1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port ReadEnable, input, 1 bit: capture ReadAddr at this edge.
REQ-009 SHALL have port ReadAddr, input, RADDR_WIDTH bits: the 64b word address.
REQ-010 SHALL have port ReadData, output, RDATA_WIDTH bits: {mem[2a+1], mem[2a]} for the registered address a.
REQ-011 SHALL have port WriteEnable, input, [N_WRITE] bits: per-port write request.
REQ-012 SHALL have port WriteAddr, input, [N_WRITE][WADDR_WIDTH] bits: per-port 32b word address.
REQ-013 SHALL have port WriteData, input, [N_WRITE][WDATA_WIDTH] bits: per-port write data.
REQ-014 SHALL have port WriteDropped, output, [N_WRITE] bits: registered per-port loss flag.

Function
REQ-015 Storage SHALL be 2**WADDR_WIDTH latch words of WDATA_WIDTH bits, with no reset and each word clocked by its own gated clock.
REQ-016 Read: the address register SHALL load ReadAddr on a rising edge when ReadEnable=1 and otherwise hold; ReadData SHALL be a combinational mux from that register, giving 1-cycle latency.
REQ-017 Write arbitration: per 32b word, the lowest-index port with WriteEnable=1 addressing that word SHALL win; each other port addressing the same word in that cycle SHALL lose.
REQ-018 Ports targeting different 32b words, including the two halves of one 64b word, SHALL all complete in the same cycle.
REQ-019 At each rising edge, every port SHALL stage WriteData, WriteAddr and WriteEnable.
REQ-020 Each word's gate enable SHALL be decoded from the unstaged inputs at that edge; the word's latch SHALL be transparent during the high phase after that edge and SHALL take the winner's staged data.
REQ-021 A write presented in cycle t SHALL be visible to a read whose address is captured at edge t+1 or later.
REQ-022 A read captured at the same edge as a write to the same word SHALL return the new data by the falling edge of clk in that cycle.
REQ-023 WriteDropped[p] SHALL be 1 for exactly the cycle after edge t iff port p lost arbitration at t, and 0 otherwise.
REQ-024 When no WriteEnable bit is set, no gated clock SHALL toggle; a global clock gate SHALL be enabled by the OR of WriteEnable.
REQ-025 All gate test-enable inputs SHALL be tied to 0.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear the read address register to 0, the staged enables to 0 and WriteDropped to 0.
REQ-027 Memory content SHALL NOT be reset; after reset, ReadData SHALL equal words 1:0, whose value is undefined until written.
REQ-028 Reset asserted mid-write SHALL suppress any latch pulse not yet issued; the content of a word caught in an active pulse is undefined.

Structure
REQ-029 No shared-package typedefs SHALL be defined; word counts SHALL be module-local constants derived from the parameters.
REQ-030 Clock gating SHALL instantiate the existing tc_clk_gating cell: one global instance plus one instance per 32b word; no other sub-module SHALL be used.

Verification
REQ-031 Port0 writes word 6 = 0x1111_1111 and port1 writes word 7 = 0x2222_2222 in the same cycle; next cycle read addr 3 -> ReadData = 0x2222_2222_1111_1111 one cycle later, WriteDropped = 0.
REQ-032 Ports 1, 2 and 3 all write word 10 (0xA1, 0xA2, 0xA3) in one cycle -> word 10 = 0xA1; WriteDropped = 4'b1100 for exactly one cycle.
REQ-033 Port3 writes word 0 = 0xDEAD_BEEF while a read of addr 0 is captured at the same edge -> ReadData[31:0] = 0xDEAD_BEEF at the falling edge.
REQ-034 Write all 64 words with the data equal to the word index, then read addr 0..31 back to back -> each ReadData = {2a+1, 2a}, 1-cycle latency.
REQ-035 With the read address held at 5, hold ReadEnable=0 and change ReadAddr -> ReadData remains word pair 11:10.
REQ-036 Assert rst_n=0 asynchronously mid-sequence -> the read address register = 0 and WriteDropped = 0 immediately; previously written words remain intact.
